// File: rtl/execute_mem_storebuffer.sv
// rtl/execute_mem_storebuffer.sv - speculative store buffer with load forwarding, commit, drain and flush
// Optional sticky error output enabled by EXECUTE_MEM_STOREBUFFER_ERRCHK_EN.
module execute_mem_storebuffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  logic        s_byte,
    input  logic        s_uncached,
    input  logic [31:0] s_data,
    input  logic [31:0] q_addr,
    output logic [3:0]  storebuffer_qstrb,
    output logic [31:0] storebuffer_qdata,
    input  logic        i_commit,
    input  logic        i_flush,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [29:0] m_addr,
    output logic [3:0]  m_strb,
    output logic [31:0] m_data,
    output logic        m_uncached
`ifdef EXECUTE_MEM_STOREBUFFER_ERRCHK_EN
    ,
    output logic        o_err
`endif
);

    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_cmt;
    logic [PTR_W:0]   r_tail;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_unc;
    logic [29:0]      r_addr [DEPTH];
    logic [3:0]       r_strb [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic [PTR_W-1:0] w_head_idx;
    logic [PTR_W-1:0] w_tail_idx;
    logic             w_enq;
    logic             w_cmt_ok;
    logic             w_drain;
    logic [PTR_W:0]   w_cmt_next;
    logic [3:0]       w_s_strb;
    logic [31:0]      w_s_data;
    logic [DEPTH-1:0] w_kill;
    logic [PTR_W-1:0] w_dist;
    logic [PTR_W-1:0] w_idx;
    logic [3:0]       w_qstrb;
    logic [31:0]      w_qdata;
    logic             w_unused;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_unused   = ^q_addr[1:0];

    assign s_ready    = (r_tail - r_head) != DEPTH_P;
    assign m_valid    = r_head != r_cmt;
    assign w_enq      = s_valid & s_ready & ~i_flush;
    assign w_cmt_ok   = i_commit & (r_cmt != r_tail);
    assign w_drain    = m_valid & m_ready;
    assign w_cmt_next = r_cmt + {{PTR_W{1'b0}}, w_cmt_ok};

    assign w_s_strb   = s_byte ? (4'b0001 << s_addr[1:0]) : 4'b1111;
    assign w_s_data   = s_byte ? {4{s_data[7:0]}} : s_data;

    assign m_addr     = r_addr[w_head_idx];
    assign m_strb     = r_strb[w_head_idx];
    assign m_data     = r_data[w_head_idx];
    assign m_uncached = r_unc[w_head_idx];

    // Flush kills every slot between the post-commit pointer and tail.
    always_comb begin
        w_kill = '0;
        w_dist = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_dist = PTR_W'(i) - w_cmt_next[PTR_W-1:0];
            w_kill[i] = i_flush && ({1'b0, w_dist} < (r_tail - w_cmt_next));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_cmt   <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_unc   <= '0;
        end else begin
            r_cmt <= w_cmt_next;
            if (i_flush)
                r_tail <= w_cmt_next;
            else if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_drain)
                r_head <= r_head + 1'b1;
            if (w_enq) begin
                r_addr[w_tail_idx] <= s_addr[31:2];
                r_strb[w_tail_idx] <= w_s_strb;
                r_data[w_tail_idx] <= w_s_data;
                r_unc[w_tail_idx]  <= s_uncached;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enq && (PTR_W'(i) == w_tail_idx))
                    r_valid[i] <= 1'b1;
                else if ((w_drain && (PTR_W'(i) == w_head_idx)) || w_kill[i])
                    r_valid[i] <= 1'b0;
            end
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier lanes.
    always_comb begin
        w_qstrb = '0;
        w_qdata = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_head_idx + PTR_W'(k);
            if (r_valid[w_idx] && !r_unc[w_idx] && (r_addr[w_idx] == q_addr[31:2])) begin
                for (int j = 0; j < 4; j++) begin
                    if (r_strb[w_idx][j]) begin
                        w_qstrb[j]       = 1'b1;
                        w_qdata[8*j +: 8] = r_data[w_idx][8*j +: 8];
                    end
                end
            end
        end
    end

    assign storebuffer_qstrb = w_qstrb;
    assign storebuffer_qdata = w_qdata;

`ifdef EXECUTE_MEM_STOREBUFFER_ERRCHK_EN
    logic [6:0] r_stall_cnt;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (s_valid && !s_ready) begin
                if (r_stall_cnt >= 7'd64)
                    r_err <= 1'b1;
                if (r_stall_cnt != 7'h7f)
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_stall_cnt <= '0;
            end
            if (i_commit && (r_cmt == r_tail))
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_execute_mem_storebuffer.sv
// tb/tb_execute_mem_storebuffer.sv - directed self-checking bench for execute_mem_storebuffer
module tb_execute_mem_storebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic        s_byte;
    logic        s_uncached;
    logic [31:0] s_data;
    logic [31:0] q_addr;
    logic [3:0]  storebuffer_qstrb;
    logic [31:0] storebuffer_qdata;
    logic        i_commit;
    logic        i_flush;
    logic        m_valid;
    logic        m_ready;
    logic [29:0] m_addr;
    logic [3:0]  m_strb;
    logic [31:0] m_data;
    logic        m_uncached;
`ifdef EXECUTE_MEM_STOREBUFFER_ERRCHK_EN
    logic        o_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_mem_storebuffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_addr(s_addr),
        .s_byte(s_byte),
        .s_uncached(s_uncached),
        .s_data(s_data),
        .q_addr(q_addr),
        .storebuffer_qstrb(storebuffer_qstrb),
        .storebuffer_qdata(storebuffer_qdata),
        .i_commit(i_commit),
        .i_flush(i_flush),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr(m_addr),
        .m_strb(m_strb),
        .m_data(m_data),
        .m_uncached(m_uncached)
`ifdef EXECUTE_MEM_STOREBUFFER_ERRCHK_EN
        ,
        .o_err(o_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_addr     = '0;
        s_byte     = 1'b0;
        s_uncached = 1'b0;
        s_data     = '0;
        q_addr     = '0;
        i_commit   = 1'b0;
        i_flush    = 1'b0;
        m_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic b, input logic u, input logic [31:0] d);
        s_valid    = 1'b1;
        s_addr     = a;
        s_byte     = b;
        s_uncached = u;
        s_data     = d;
        tick();
        s_valid    = 1'b0;
    endtask

    task automatic do_commit();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    task automatic do_drain();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic set_query(input logic [31:0] a);
        q_addr = a;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        set_query(32'h0);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%0h exp=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0h exp=0", m_valid); end
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL reset_qstrb got=%h exp=0", storebuffer_qstrb); end
        checks++; if (storebuffer_qdata !== 32'h0) begin failures++; $display("FAIL reset_qdata got=%h exp=0", storebuffer_qdata); end
    endtask

    task automatic test_word_forward();
        apply_reset();
        do_store(32'h100, 1'b0, 1'b0, 32'hAABBCCDD);
        set_query(32'h100);
        checks++; if (storebuffer_qstrb !== 4'hF) begin failures++; $display("FAIL word_qstrb got=%h exp=f", storebuffer_qstrb); end
        checks++; if (storebuffer_qdata !== 32'hAABBCCDD) begin failures++; $display("FAIL word_qdata got=%h exp=aabbccdd", storebuffer_qdata); end
        set_query(32'h104);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL word_miss_qstrb got=%h exp=0", storebuffer_qstrb); end
        checks++; if (storebuffer_qdata !== 32'h0) begin failures++; $display("FAIL word_miss_qdata got=%h exp=0", storebuffer_qdata); end
    endtask

    task automatic test_byte_merge();
        apply_reset();
        do_store(32'h200, 1'b0, 1'b0, 32'h11223344);
        do_store(32'h202, 1'b1, 1'b0, 32'h00000099);
        set_query(32'h200);
        checks++; if (storebuffer_qstrb !== 4'hF) begin failures++; $display("FAIL merge_qstrb got=%h exp=f", storebuffer_qstrb); end
        checks++; if (storebuffer_qdata !== 32'h11993344) begin failures++; $display("FAIL merge_qdata got=%h exp=11993344", storebuffer_qdata); end
        set_query(32'h203);
        checks++; if (storebuffer_qdata !== 32'h11993344) begin failures++; $display("FAIL merge_lowbits_qdata got=%h exp=11993344", storebuffer_qdata); end
    endtask

    task automatic test_full_drain();
        apply_reset();
        for (int i = 0; i < 4; i++)
            do_store(32'h10 + 32'(4*i), 1'b0, 1'b0, 32'hA0 + 32'(i));
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%0h exp=0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL full_m_valid_nocommit got=%0h exp=0", m_valid); end
        do_store(32'h20, 1'b0, 1'b0, 32'hDEAD);
        set_query(32'h20);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL full_dropped_qstrb got=%h exp=0", storebuffer_qstrb); end
        do_commit();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL full_m_valid got=%0h exp=1", m_valid); end
        checks++; if (m_addr !== 30'h4) begin failures++; $display("FAIL full_m_addr got=%h exp=4", m_addr); end
        checks++; if (m_data !== 32'hA0) begin failures++; $display("FAIL full_m_data got=%h exp=a0", m_data); end
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready_during_drain got=%0h exp=0", s_ready); end
        tick();
        m_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_s_ready_after got=%0h exp=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL full_m_valid_after got=%0h exp=0", m_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        do_store(32'h500, 1'b0, 1'b0, 32'h01010101);
        do_store(32'h504, 1'b0, 1'b0, 32'h02020202);
        do_store(32'h508, 1'b0, 1'b0, 32'h03030303);
        do_commit();
        i_commit   = 1'b1;
        i_flush    = 1'b1;
        s_valid    = 1'b1;
        s_addr     = 32'h50C;
        s_byte     = 1'b0;
        s_data     = 32'h04040404;
        tick();
        i_commit = 1'b0;
        i_flush  = 1'b0;
        s_valid  = 1'b0;
        set_query(32'h508);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL flush_508_qstrb got=%h exp=0", storebuffer_qstrb); end
        set_query(32'h50C);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL flush_dropped_qstrb got=%h exp=0", storebuffer_qstrb); end
        set_query(32'h504);
        checks++; if (storebuffer_qdata !== 32'h02020202) begin failures++; $display("FAIL flush_kept_qdata got=%h exp=02020202", storebuffer_qdata); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL flush_m_valid got=%0h exp=1", m_valid); end
        checks++; if (m_addr !== 30'h140) begin failures++; $display("FAIL flush_m_addr0 got=%h exp=140", m_addr); end
        do_drain();
        checks++; if (m_addr !== 30'h141) begin failures++; $display("FAIL flush_m_addr1 got=%h exp=141", m_addr); end
        do_drain();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_m_valid_end got=%0h exp=0", m_valid); end
        set_query(32'h500);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL flush_drained_qstrb got=%h exp=0", storebuffer_qstrb); end
    endtask

    task automatic test_uncached();
        apply_reset();
        do_store(32'h300, 1'b1, 1'b1, 32'h0000005A);
        set_query(32'h300);
        checks++; if (storebuffer_qstrb !== 4'h0) begin failures++; $display("FAIL unc_qstrb got=%h exp=0", storebuffer_qstrb); end
        do_commit();
        checks++; if (m_uncached !== 1'b1) begin failures++; $display("FAIL unc_m_uncached got=%0h exp=1", m_uncached); end
        checks++; if (m_strb !== 4'b0001) begin failures++; $display("FAIL unc_m_strb got=%b exp=0001", m_strb); end
        checks++; if (m_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL unc_m_data got=%h exp=5a5a5a5a", m_data); end
        checks++; if (m_addr !== 30'hC0) begin failures++; $display("FAIL unc_m_addr got=%h exp=c0", m_addr); end
        do_drain();
    endtask

    task automatic test_illegal_commit();
        apply_reset();
        do_commit();
        do_store(32'h700, 1'b0, 1'b0, 32'h77);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL illegal_commit_m_valid got=%0h exp=0", m_valid); end
        do_commit();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL legal_commit_m_valid got=%0h exp=1", m_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            do_store(32'h600 + 32'(4*i), 1'b0, 1'b0, 32'(i));
            do_commit();
            checks++; if (m_addr !== 30'h180 + 30'(i)) begin failures++; $display("FAIL wrap_m_addr_%0d got=%h exp=%h", i, m_addr, 30'h180 + 30'(i)); end
            do_drain();
        end
        do_store(32'h400, 1'b0, 1'b0, 32'hCAFEF00D);
        do_store(32'h404, 1'b0, 1'b0, 32'h12345678);
        do_store(32'h401, 1'b1, 1'b0, 32'h00000077);
        set_query(32'h400);
        checks++; if (storebuffer_qstrb !== 4'hF) begin failures++; $display("FAIL wrap_qstrb got=%h exp=f", storebuffer_qstrb); end
        checks++; if (storebuffer_qdata !== 32'hCAFE770D) begin failures++; $display("FAIL wrap_qdata got=%h exp=cafe770d", storebuffer_qdata); end
        set_query(32'h404);
        checks++; if (storebuffer_qdata !== 32'h12345678) begin failures++; $display("FAIL wrap_qdata_404 got=%h exp=12345678", storebuffer_qdata); end
        do_commit();
        do_commit();
        do_commit();
        checks++; if (m_addr !== 30'h100) begin failures++; $display("FAIL wrap_order0 got=%h exp=100", m_addr); end
        do_drain();
        checks++; if (m_addr !== 30'h101) begin failures++; $display("FAIL wrap_order1 got=%h exp=101", m_addr); end
        do_drain();
        checks++; if (m_strb !== 4'b0010) begin failures++; $display("FAIL wrap_order2_strb got=%b exp=0010", m_strb); end
        do_drain();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%0h exp=0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_word_forward();
        test_byte_merge();
        test_full_drain();
        test_flush();
        test_uncached();
        test_illegal_commit();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
